// File: rtl/rle_run_decoder.sv
// Run-length pixel decoder: turns {len, colour} run words into one colour per active pixel,
// with a one-word prefetch, optional 2x horizontal scaling, end-of-frame marker and underrun flag.
module rle_run_decoder #(
  parameter int COLOUR_BITS  = 6,
  parameter int LEN_BITS     = 10,
  parameter int BLANK_COLOUR = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_start,
  input  logic                            pixel_en,
  input  logic                            hscale,
  input  logic [LEN_BITS+COLOUR_BITS-1:0] data_in,
  input  logic                            data_valid,
  output logic                            data_ready,
  output logic [COLOUR_BITS-1:0]          colour_out,
  output logic                            eof,
  output logic                            underrun,
  input  logic                            status_clr
);

  localparam logic [COLOUR_BITS-1:0] BLANK = COLOUR_BITS'(BLANK_COLOUR);

  logic [COLOUR_BITS-1:0]          cur_colour;
  logic [LEN_BITS-1:0]             cur_rem;
  logic                            cur_valid;
  logic [LEN_BITS+COLOUR_BITS-1:0] nxt_word;
  logic                            nxt_valid;
  logic                            phase;
  logic                            hscale_mode;

  logic [LEN_BITS-1:0]    nxt_len;
  logic [COLOUR_BITS-1:0] nxt_colour;
  logic                   consume;
  logic                   unit_done;
  logic                   run_end;
  logic                   load;
  logic                   accept;

  assign nxt_len    = nxt_word[LEN_BITS+COLOUR_BITS-1:COLOUR_BITS];
  assign nxt_colour = nxt_word[COLOUR_BITS-1:0];
  assign data_ready = !nxt_valid && !eof && !frame_start;

  // The cur slot frees up on the very edge that consumes its last unit, so a waiting
  // prefetch word slides in without a bubble.
  always_comb begin
    consume   = pixel_en && !eof && cur_valid;
    unit_done = consume && (!hscale_mode || phase);
    run_end   = unit_done && (cur_rem == LEN_BITS'(1));
    load      = (!cur_valid || run_end) && nxt_valid;
    accept    = data_valid && data_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colour_out  <= BLANK;
      eof         <= 1'b0;
      cur_colour  <= BLANK;
      cur_rem     <= '0;
      cur_valid   <= 1'b0;
      nxt_word    <= '0;
      nxt_valid   <= 1'b0;
      phase       <= 1'b0;
      hscale_mode <= 1'b0;
    end else if (frame_start) begin
      colour_out  <= BLANK;
      eof         <= 1'b0;
      cur_valid   <= 1'b0;
      nxt_valid   <= 1'b0;
      phase       <= 1'b0;
      hscale_mode <= hscale;
    end else begin
      colour_out <= consume ? cur_colour : BLANK;
      if (consume && hscale_mode) begin
        phase <= !phase;
      end
      if (unit_done) begin
        cur_rem <= cur_rem - LEN_BITS'(1);
      end
      // A zero-length word is the end-of-frame marker rather than a run.
      if (load) begin
        nxt_valid <= 1'b0;
        if (nxt_len != '0) begin
          cur_colour <= nxt_colour;
          cur_rem    <= nxt_len;
          cur_valid  <= 1'b1;
        end else begin
          cur_valid <= 1'b0;
          eof       <= 1'b1;
        end
      end else if (run_end) begin
        cur_valid <= 1'b0;
      end
      if (accept) begin
        nxt_word  <= data_in;
        nxt_valid <= 1'b1;
      end
    end
  end

  // Sticky underrun: survives frame_start; a new underrun beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (pixel_en && !eof && !cur_valid && !frame_start) begin
      underrun <= 1'b1;
    end else if (status_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule
